// File: rtl/xor_stream_cipher_pkg.sv
// -----------------------------------------------------------------------------
// cipher_pkg
// Shared definitions for the xor_stream_cipher block: FSM state encoding,
// keystream mode constants and the default LFSR feedback mask.
// No ports (package).
// -----------------------------------------------------------------------------
package cipher_pkg;

  // Top-level control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CRYPT = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // Keystream selection, sampled from iMode when encryption starts
  localparam logic MODE_REPEAT = 1'b0;
  localparam logic MODE_LFSR   = 1'b1;

  // Galois feedback mask used when the caller does not override LFSR_TAPS
  localparam logic [7:0] DEFAULT_LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/xor_stream_cipher_if.sv
// -----------------------------------------------------------------------------
// xor_stream_cipher_if
// Serial data/flag bundle between the pin wrapper (master) and the cipher
// core (slave).
//   iData_in            serial data in, MSB first
//   iKey_flag/iMsg_flag iData_in carries a key / message bit
//   iMode               0 = repeating key, 1 = LFSR keystream
//   oBusy               core is in CRYPT or SHIFT
//   oEncryption_status  high during CRYPT cycles only
//   oData_flag/oData_out serial ciphertext, MSB first
//   oDone               one-cycle pulse after the last ciphertext bit
// -----------------------------------------------------------------------------
interface xor_stream_cipher_if;

  logic iData_in;
  logic iKey_flag;
  logic iMsg_flag;
  logic iMode;
  logic oBusy;
  logic oEncryption_status;
  logic oData_flag;
  logic oData_out;
  logic oDone;

  modport master (
    output iData_in, iKey_flag, iMsg_flag, iMode,
    input  oBusy, oEncryption_status, oData_flag, oData_out, oDone
  );

  modport slave (
    input  iData_in, iKey_flag, iMsg_flag, iMode,
    output oBusy, oEncryption_status, oData_flag, oData_out, oDone
  );

endinterface

// File: rtl/xor_stream_cipher_keystream_gen.sv
// -----------------------------------------------------------------------------
// keystream_gen
// Produces one KEY_SIZE-bit keystream word per CRYPT cycle. The word register
// is seeded with the key; in LFSR mode each step advances it as a Galois LFSR,
// in repeat mode it simply holds the key.
//   clk, rst (sync, active-high), ena (freeze when low)
//   i_load  load i_seed into the word register (takes priority over step)
//   i_seed  key word
//   i_step  advance to the next keystream word
//   i_mode  MODE_REPEAT / MODE_LFSR
//   o_word  current keystream word
// -----------------------------------------------------------------------------
module keystream_gen
  import cipher_pkg::*;
#(
  parameter int                  KEY_SIZE  = 8,
  parameter logic [KEY_SIZE-1:0] LFSR_TAPS = KEY_SIZE'(DEFAULT_LFSR_TAPS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                i_load,
  input  logic [KEY_SIZE-1:0] i_seed,
  input  logic                i_step,
  input  logic                i_mode,
  output logic [KEY_SIZE-1:0] o_word
);

  logic [KEY_SIZE-1:0] r_lfsr;
  logic [KEY_SIZE-1:0] w_lfsr_next;

  // Galois step: shift right, fold the taps in when the dropped bit was 1.
  // An all-zero seed stays all-zero, which is an accepted keystream.
  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : {KEY_SIZE{1'b0}});

  // Keystream word register: seed on load, advance only in LFSR mode
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= {KEY_SIZE{1'b0}};
    end else if (ena) begin
      if (i_load) begin
        r_lfsr <= i_seed;
      end else if (i_step && (i_mode == MODE_LFSR)) begin
        r_lfsr <= w_lfsr_next;
      end else begin
        r_lfsr <= r_lfsr;
      end
    end
  end

  assign o_word = r_lfsr;

endmodule

// File: rtl/xor_stream_cipher.sv
// -----------------------------------------------------------------------------
// xor_stream_cipher
// Serially loads a KEY_SIZE-bit key and a MSG_SIZE-bit message, XORs the
// message chunk by chunk (one KEY_SIZE chunk per CRYPT cycle) with a repeating
// key or an LFSR keystream, then shifts the ciphertext out MSB first.
//   clk  single clock
//   rst  synchronous, active-high reset
//   ena  global enable; low freezes every register
//   bus  xor_stream_cipher_if.slave (serial data, flags, mode, status)
// -----------------------------------------------------------------------------
module xor_stream_cipher
  import cipher_pkg::*;
#(
  parameter int                  MSG_SIZE  = 64,
  parameter int                  KEY_SIZE  = 8,
  parameter logic [KEY_SIZE-1:0] LFSR_TAPS = KEY_SIZE'(DEFAULT_LFSR_TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  xor_stream_cipher_if.slave bus
);

  localparam int N_CHUNKS = MSG_SIZE / KEY_SIZE;
  localparam int KCW      = $clog2(KEY_SIZE) + 1;
  localparam int MCW      = $clog2(MSG_SIZE) + 1;
  localparam int CCW      = $clog2(N_CHUNKS) + 1;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_crypt_start;
  logic                w_shift_done;

  logic [KEY_SIZE-1:0] r_key;
  logic [KCW-1:0]      r_key_cnt;
  logic                r_key_used;
  logic [MSG_SIZE-1:0] r_msg;
  logic [MCW-1:0]      r_msg_cnt;
  logic [MSG_SIZE-1:0] r_ct;
  logic [CCW-1:0]      r_chunk_cnt;
  logic [MCW-1:0]      r_bit_cnt;
  logic                r_mode;

  logic                r_busy;
  logic                r_enc;
  logic                r_dflag;
  logic                r_dout;
  logic                r_done;

  logic [KEY_SIZE-1:0] w_ks;
  logic [KEY_SIZE-1:0] w_ct_word;
  logic [MSG_SIZE-1:0] w_ct_next;

  // Next-state logic
  always_comb begin
    w_state_next  = r_state;
    w_crypt_start = 1'b0;
    case (r_state)
      IDLE: begin
        if ((r_key_cnt == KCW'(KEY_SIZE)) && (r_msg_cnt == MCW'(MSG_SIZE)) &&
            !bus.iKey_flag && !bus.iMsg_flag) begin
          w_state_next  = CRYPT;
          w_crypt_start = 1'b1;
        end else begin
          w_state_next  = IDLE;
        end
      end
      CRYPT: begin
        if (r_chunk_cnt == CCW'(N_CHUNKS - 1)) begin
          w_state_next = SHIFT;
        end else begin
          w_state_next = CRYPT;
        end
      end
      SHIFT: begin
        if (r_bit_cnt == MCW'(MSG_SIZE - 1)) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = SHIFT;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_shift_done = (r_state == SHIFT) && (w_state_next == IDLE);

  // The chunk in flight is always the message MSBs because the message
  // register shifts left by one chunk each CRYPT cycle. The ciphertext
  // accumulates the same way, so chunk 0 ends up at the MSB.
  assign w_ct_word = r_msg[MSG_SIZE-1 -: KEY_SIZE] ^ w_ks;
  assign w_ct_next = (r_ct << KEY_SIZE) | MSG_SIZE'(w_ct_word);

  keystream_gen #(
    .KEY_SIZE  (KEY_SIZE),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_keystream (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .i_load (w_crypt_start),
    .i_seed (r_key),
    .i_step (r_state == CRYPT),
    .i_mode (r_mode),
    .o_word (w_ks)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (ena) begin
      r_state <= w_state_next;
    end
  end

  // Key shift register; a finished encryption marks the key as reusable so a
  // later key bit starts a fresh load instead of being dropped by saturation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key      <= {KEY_SIZE{1'b0}};
      r_key_cnt  <= {KCW{1'b0}};
      r_key_used <= 1'b0;
    end else if (ena) begin
      if (w_shift_done) begin
        r_key_used <= 1'b1;
      end else if ((r_state == IDLE) && bus.iKey_flag) begin
        if (r_key_used) begin
          r_key      <= {r_key[KEY_SIZE-2:0], bus.iData_in};
          r_key_cnt  <= KCW'(1);
          r_key_used <= 1'b0;
        end else if (r_key_cnt != KCW'(KEY_SIZE)) begin
          r_key      <= {r_key[KEY_SIZE-2:0], bus.iData_in};
          r_key_cnt  <= r_key_cnt + KCW'(1);
        end
      end
    end
  end

  // Message shift register; a key bit on the same cycle wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_msg     <= {MSG_SIZE{1'b0}};
      r_msg_cnt <= {MCW{1'b0}};
    end else if (ena) begin
      if ((r_state == IDLE) && !bus.iKey_flag && bus.iMsg_flag &&
          (r_msg_cnt != MCW'(MSG_SIZE))) begin
        r_msg     <= {r_msg[MSG_SIZE-2:0], bus.iData_in};
        r_msg_cnt <= r_msg_cnt + MCW'(1);
      end else if (r_state == CRYPT) begin
        r_msg     <= r_msg << KEY_SIZE;
      end else if (w_shift_done) begin
        r_msg_cnt <= {MCW{1'b0}};
      end
    end
  end

  // Keystream mode is captured once so it cannot change mid-message
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= MODE_REPEAT;
    end else if (ena && w_crypt_start) begin
      r_mode <= bus.iMode;
    end
  end

  // Ciphertext datapath: chunk accumulation in CRYPT, serialisation in SHIFT.
  // The first output bit is taken from w_ct_next so it is ready on the edge
  // that enters SHIFT, even when there is only one chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ct        <= {MSG_SIZE{1'b0}};
      r_chunk_cnt <= {CCW{1'b0}};
      r_bit_cnt   <= {MCW{1'b0}};
      r_dout      <= 1'b0;
    end else if (ena) begin
      case (r_state)
        IDLE: begin
          r_chunk_cnt <= {CCW{1'b0}};
          r_bit_cnt   <= {MCW{1'b0}};
          r_dout      <= 1'b0;
        end
        CRYPT: begin
          r_chunk_cnt <= r_chunk_cnt + CCW'(1);
          if (w_state_next == SHIFT) begin
            r_ct   <= {w_ct_next[MSG_SIZE-2:0], 1'b0};
            r_dout <= w_ct_next[MSG_SIZE-1];
          end else begin
            r_ct   <= w_ct_next;
            r_dout <= 1'b0;
          end
        end
        SHIFT: begin
          r_bit_cnt <= r_bit_cnt + MCW'(1);
          r_ct      <= {r_ct[MSG_SIZE-2:0], 1'b0};
          r_dout    <= w_shift_done ? 1'b0 : r_ct[MSG_SIZE-1];
        end
        default: begin
          r_dout <= 1'b0;
        end
      endcase
    end
  end

  // Status outputs registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_enc   <= 1'b0;
      r_dflag <= 1'b0;
      r_done  <= 1'b0;
    end else if (ena) begin
      r_busy  <= (w_state_next != IDLE);
      r_enc   <= (w_state_next == CRYPT);
      r_dflag <= (w_state_next == SHIFT);
      r_done  <= w_shift_done;
    end
  end

  assign bus.oBusy              = r_busy;
  assign bus.oEncryption_status = r_enc;
  assign bus.oData_flag         = r_dflag;
  assign bus.oData_out          = r_dout;
  assign bus.oDone              = r_done;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// -----------------------------------------------------------------------------
// tb_xor_stream_cipher
// Self-checking bench: drives serial key/message loads, captures the serial
// ciphertext and window timing, and compares against a chunk-level model.
// -----------------------------------------------------------------------------
module tb_xor_stream_cipher;

  logic clk = 1'b0;
  logic rst;
  logic ena;

  xor_stream_cipher_if bus_if();

  xor_stream_cipher #(
    .MSG_SIZE  (64),
    .KEY_SIZE  (8),
    .LFSR_TAPS (8'hB8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] outs;
  assign outs = {bus_if.oBusy, bus_if.oEncryption_status, bus_if.oData_flag,
                 bus_if.oData_out, bus_if.oDone};

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Chunk-level reference: word i of the message XOR keystream word i
  function automatic logic [63:0] model_ct(input logic [7:0] key, input logic [63:0] msg,
                                           input bit lfsr_mode);
    logic [7:0]  ks;
    logic [63:0] ct;
    ks = key;
    ct = 64'd0;
    for (int i = 0; i < 8; i++) begin
      ct[63 - 8*i -: 8] = msg[63 - 8*i -: 8] ^ ks;
      if (lfsr_mode) ks = (ks >> 1) ^ (ks[0] ? 8'hB8 : 8'h00);
    end
    return ct;
  endfunction

  task automatic send_bits(input logic [127:0] val, input int nbits, input bit as_key);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus_if.iData_in  = val[i];
      bus_if.iKey_flag = as_key;
      bus_if.iMsg_flag = !as_key;
      tick();
    end
    bus_if.iKey_flag = 1'b0;
    bus_if.iMsg_flag = 1'b0;
    bus_if.iData_in  = 1'b0;
  endtask

  // Flags must already be low; the next edge starts encryption.
  task automatic run_crypt(input string tag, input logic [63:0] exp_ct, input int pause_at);
    logic [63:0] ct;
    int cyc, enc_n, flag_n, done_n, done_cyc, first_flag, rises, first_enc;
    logic prev_flag, held_d, held_f;
    ct = 64'd0; cyc = 0; enc_n = 0; flag_n = 0; done_n = 0; done_cyc = 0;
    first_flag = 0; rises = 0; first_enc = 0; prev_flag = 1'b0;
    while (cyc < 200 && (done_cyc == 0 || cyc < done_cyc + 3)) begin
      tick();
      cyc++;
      if (cyc == 1) bus_if.iMode = ~bus_if.iMode;  // must already be latched
      if (bus_if.oEncryption_status) begin
        enc_n++;
        if (first_enc == 0) first_enc = cyc;
      end
      if (bus_if.oData_flag) begin
        flag_n++;
        ct = {ct[62:0], bus_if.oData_out};
        if (!prev_flag) begin
          rises++;
          first_flag = cyc;
        end
      end
      prev_flag = bus_if.oData_flag;
      if (bus_if.oDone) begin
        done_n++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          check_val({tag, "_busy_at_done"}, 64'(bus_if.oBusy), 64'd0);
        end
      end
      if (pause_at != 0 && cyc == pause_at) begin
        held_d = bus_if.oData_out;
        held_f = bus_if.oData_flag;
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          check_val({tag, "_hold_dout"}, 64'(bus_if.oData_out), 64'(held_d));
          check_val({tag, "_hold_flag"}, 64'(bus_if.oData_flag), 64'(held_f));
        end
        ena = 1'b1;
      end
    end
    check_val({tag, "_ct"},         ct,              exp_ct);
    check_val({tag, "_enc_cycles"}, 64'(enc_n),      64'd8);
    check_val({tag, "_enc_start"},  64'(first_enc),  64'd1);
    check_val({tag, "_flag_bits"},  64'(flag_n),     64'd64);
    check_val({tag, "_flag_runs"},  64'(rises),      64'd1);
    check_val({tag, "_flag_start"}, 64'(first_flag), 64'd9);
    check_val({tag, "_done_count"}, 64'(done_n),     64'd1);
    check_val({tag, "_done_cycle"}, 64'(done_cyc),   64'd73);
  endtask

  logic [7:0]  key;
  logic [63:0] msg;
  logic [5:0]  extra;
  bit          mode;
  int          busy_n;

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    bus_if.iData_in  = 1'b0;
    bus_if.iKey_flag = 1'b0;
    bus_if.iMsg_flag = 1'b0;
    bus_if.iMode     = 1'b0;
    repeat (3) tick();
    check_val("reset_outputs", 64'(outs), 64'd0);
    rst = 1'b0;
    tick();

    // Repeating key, published vector
    send_bits(128'(8'hA5), 8, 1'b1);
    send_bits(128'(64'h0123456789ABCDEF), 64, 1'b0);
    bus_if.iMode = 1'b0;
    run_crypt("repeat", 64'hA486E0C22C0E684A, 0);
    check_val("repeat_model", model_ct(8'hA5, 64'h0123456789ABCDEF, 1'b0), 64'hA486E0C22C0E684A);

    // Key reuse: message only
    send_bits(128'(64'hFFFFFFFFFFFFFFFF), 64, 1'b0);
    bus_if.iMode = 1'b0;
    run_crypt("reuse", 64'h5A5A5A5A5A5A5A5A, 0);

    // LFSR keystream, published vector
    send_bits(128'(8'h01), 8, 1'b1);
    send_bits(128'(64'd0), 64, 1'b0);
    bus_if.iMode = 1'b1;
    run_crypt("lfsr", 64'h01B85C2E17B3E1C8, 0);

    // Both flags high for 3 key bits, then 70 message bits
    key = 8'h3C;
    msg = {$urandom, $urandom};
    extra = 6'($urandom);
    for (int i = 7; i >= 0; i--) begin
      bus_if.iData_in  = key[i];
      bus_if.iKey_flag = 1'b1;
      bus_if.iMsg_flag = (i >= 3 && i <= 5);
      tick();
    end
    bus_if.iKey_flag = 1'b0;
    bus_if.iMsg_flag = 1'b0;
    send_bits({58'd0, msg, extra}, 70, 1'b0);
    bus_if.iMode = 1'b0;
    run_crypt("both_flags", model_ct(key, msg, 1'b0), 0);

    // ena low for 5 cycles in the middle of SHIFT
    key = 8'($urandom);
    msg = {$urandom, $urandom};
    send_bits(128'(key), 8, 1'b1);
    send_bits(128'(msg), 64, 1'b0);
    bus_if.iMode = 1'b1;
    run_crypt("ena_pause", model_ct(key, msg, 1'b1), 30);

    // Reset in the middle of CRYPT
    key = 8'($urandom);
    msg = {$urandom, $urandom};
    send_bits(128'(key), 8, 1'b1);
    send_bits(128'(msg), 64, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_val("rst_mid_crypt_outputs", 64'(outs), 64'd0);
    rst = 1'b0;
    msg = {$urandom, $urandom};
    send_bits(128'(msg), 64, 1'b0);
    busy_n = 0;
    repeat (20) begin
      tick();
      if (bus_if.oBusy) busy_n++;
    end
    check_val("no_start_without_key", 64'(busy_n), 64'd0);
    key = 8'($urandom);
    send_bits(128'(key), 8, 1'b1);
    bus_if.iMode = 1'b1;
    run_crypt("after_rst", model_ct(key, msg, 1'b1), 0);

    // Random traffic, sometimes reusing the current key
    for (int n = 0; n < 6; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        key = 8'($urandom);
        send_bits(128'(key), 8, 1'b1);
      end
      msg  = {$urandom, $urandom};
      mode = 1'($urandom_range(0, 1));
      send_bits(128'(msg), 64, 1'b0);
      bus_if.iMode = mode;
      run_crypt($sformatf("rand%0d", n), model_ct(key, msg, mode), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xor_stream_cipher.md
# xor_stream_cipher

Parametrised successor to the fixed 64-bit/8-bit XOR core: one block that serially loads a key and a message, encrypts the message chunk by chunk, and serially returns the ciphertext. Widths are generic, and a keystream mode is selectable: repeating key, or an LFSR keystream seeded by the key. It exposes an encryption-window strobe for power-capture triggering. It sits directly behind the Tiny Tapeout pin wrapper, which only maps pins to ports.

## Interface
- MSG_SIZE, 64, message/ciphertext width in bits; must be a multiple of KEY_SIZE.
- KEY_SIZE, 8, key and keystream word width in bits; must be ≥2.
- LFSR_TAPS, 8'hB8 (width KEY_SIZE), Galois feedback mask for LFSR mode.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- ena  in  1  global enable; low freezes every register (outputs hold).
- iData_in  in  1  shared serial data input, MSB first.
- iKey_flag  in  1  high: iData_in is a key bit.
- iMsg_flag  in  1  high: iData_in is a message bit.
- iMode  in  1  0 = repeating key, 1 = LFSR keystream.
- oBusy  out  1  high in CRYPT and SHIFT.
- oEncryption_status  out  1  high exactly during CRYPT cycles.
- oData_flag  out  1  high while oData_out carries a valid ciphertext bit.
- oData_out  out  1  serial ciphertext, MSB first.
- oDone  out  1  one-cycle pulse after the last ciphertext bit.

## Operation
- States: IDLE, CRYPT, SHIFT.
- Reset: state IDLE. Key, message, ciphertext and the key/msg/chunk/bit counters are all 0. All outputs are 0.
- IDLE, key load: on each enabled cycle with iKey_flag=1, shift iData_in into the key LSB and increment key_cnt. key_cnt saturates at KEY_SIZE; bits beyond that are ignored.
- IDLE, message load: same behaviour on msg_cnt and MSG_SIZE, using iMsg_flag.
- Both flags high: key takes priority; the message does not shift that cycle.
- IDLE→CRYPT when key_cnt==KEY_SIZE, msg_cnt==MSG_SIZE, and both flags are low. iMode is latched at this transition.
- CRYPT:
  - Processes one chunk per cycle for N=MSG_SIZE/KEY_SIZE cycles.
  - Chunk i is message bits [MSG_SIZE-1-i·KEY_SIZE -: KEY_SIZE], so chunk 0 is the first-received word.
  - ct_i = chunk_i XOR ks_i.
  - Repeat mode: ks_i = key.
  - LFSR mode: ks_0 = key, ks_{i+1} = (ks_i>>1) ^ (ks_i[0] ? LFSR_TAPS : 0). An all-zero key yields an all-zero keystream; this is legal.
- CRYPT→SHIFT after chunk N-1 is written.
- SHIFT: output ciphertext MSB first, one bit per enabled cycle, for MSG_SIZE cycles.
- SHIFT→IDLE after the last bit:
  - oDone pulses.
  - msg_cnt clears.
  - Key and key_cnt are retained, so the next message reuses the key without reloading. Loading a new key restarts key_cnt from 0.
- iKey_flag and iMsg_flag are ignored in CRYPT and SHIFT.
- rst mid-operation aborts to the reset state on the next edge; no partial output follows.

## Timing
- Load: one bit accepted per enabled cycle with a flag high; no backpressure.
- Cycle E is the edge entering CRYPT.
- oEncryption_status is high for exactly N cycles, starting the cycle after E.
- oData_flag is high for exactly MSG_SIZE consecutive cycles immediately after the CRYPT window; oData_out is valid on each of those cycles.
- oDone is high the single cycle after the last flagged bit, with oBusy already 0.
- Total from E to oDone: N + MSG_SIZE + 1 cycles.
- ena low stretches all windows: the same bit and flag hold, and no counter advances.

## Structure
- Package cipher_pkg holds:
  - state enum: IDLE, CRYPT, SHIFT;
  - mode constants: MODE_REPEAT=0, MODE_LFSR=1;
  - default LFSR_TAPS.
- Sub-module keystream_gen(KEY_SIZE, LFSR_TAPS) has seed load, step, word out and mode input. It holds the only LFSR register.
- FSM, shift registers and counters live in the top of this block. Counter widths are $clog2(size)+1.

## Test plan
- Repeat mode: KEY 8'hA5, MSG 64'h0123456789ABCDEF → serial ciphertext 64'hA486E0C22C0E684A. oEncryption_status is high 8 cycles; oData_flag is high 64 cycles; one oDone pulse.
- LFSR mode: KEY 8'h01, MSG all zeros, TAPS 8'hB8 → ciphertext 64'h01B85C2E17B3E1C8.
- Key reuse: after the first test, load only MSG 64'hFFFFFFFFFFFFFFFF → 64'h5A5A5A5A5A5A5A5A with no key reload.
- Simultaneous flags: both high for 3 cycles during key load → key receives those bits and msg_cnt is unchanged. 70 message bits sent → only the first 64 are kept.
- ena low for 5 cycles mid-SHIFT → oData_out/oData_flag hold, and the bitstream resumes unbroken.
- rst asserted mid-CRYPT → next cycle all outputs are 0 and state is IDLE; a new key is required before encryption starts.
